// File: rtl/adc_readout_ctrl.sv
// Sequences a multi-channel serial ADC and its downstream word parser, emitting
// {channel, word} samples on a valid/ready stream. Optional: ADC_CTRL_CONTINUOUS_EN.
module adc_readout_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 15,
  parameter int SETTLE_CYC = 8,
  parameter int CONV_CYC   = 40,
  parameter int SCK_HALF   = 2,
  parameter int WORD_TO    = 4,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [CH_W-1:0]        ch_sel_o,
  output logic                   adc_cnv_o,
  output logic                   adc_sck_o,
  input  logic                   adc_sdo_i,
  output logic                   bit_valid_o,
  output logic                   bit_o,
  input  logic                   word_valid_i,
  input  logic [DATA_W-1:0]      word_i,
  output logic                   out_valid_o,
  output logic [CH_W+DATA_W-1:0] out_data_o,
  input  logic                   out_ready_i
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int CNV_W = (CONV_CYC > 1) ? $clog2(CONV_CYC) : 1;
  localparam int PH_W  = $clog2(2 * SCK_HALF);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TO_W  = (WORD_TO > 1) ? $clog2(WORD_TO) : 1;
  localparam int OUT_W = CH_W + DATA_W;

  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNV_W-1:0] CNV_LAST = CNV_W'(CONV_CYC - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * SCK_HALF - 1);
  localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(SCK_HALF);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(WORD_TO - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CONV,
    S_SHIFT,
    S_WAIT,
    S_OUT
  } state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
  logic [CNV_W-1:0]   cnv_cnt_q, cnv_cnt_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic               got_q, got_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               cnv_q, cnv_d;
  logic               sck_q, sck_d;
  logic               bv_q, bv_d;
  logic               bit_q, bit_d;
  logic               ov_q, ov_d;
  logic [OUT_W-1:0]   od_q, od_d;
  logic               win;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      set_cnt_q <= '0;
      cnv_cnt_q <= '0;
      ph_q      <= '0;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      word_q    <= '0;
      got_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cnv_q     <= 1'b0;
      sck_q     <= 1'b0;
      bv_q      <= 1'b0;
      bit_q     <= 1'b0;
      ov_q      <= 1'b0;
      od_q      <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      set_cnt_q <= set_cnt_d;
      cnv_cnt_q <= cnv_cnt_d;
      ph_q      <= ph_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      word_q    <= word_d;
      got_q     <= got_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cnv_q     <= cnv_d;
      sck_q     <= sck_d;
      bv_q      <= bv_d;
      bit_q     <= bit_d;
      ov_q      <= ov_d;
      od_q      <= od_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    set_cnt_d = set_cnt_q;
    cnv_cnt_d = cnv_cnt_q;
    ph_d      = ph_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    word_d    = word_q;
    got_d     = got_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    cnv_d     = 1'b0;
    sck_d     = 1'b0;
    bv_d      = 1'b0;
    bit_d     = bit_q;
    ov_d      = ov_q;
    od_d      = od_q;

    // The parser answers one cycle after the last bit pulse, which can still be
    // inside the final SCK-high phase, so the word window opens there already.
    win = ((state_q == S_SHIFT) && (bit_cnt_q == BIT_LAST) && (ph_q > PH_RISE)) ||
          (state_q == S_WAIT);
    if (win && !got_q) begin
      if (word_valid_i) begin
        word_d = word_i;
        got_d  = 1'b1;
      end else if (to_cnt_q == TO_LAST) begin
        word_d = '0;
        got_d  = 1'b1;
        err_d  = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !busy_q) begin
          state_d   = S_SETTLE;
          ch_d      = '0;
          busy_d    = 1'b1;
          err_d     = 1'b0;
          set_cnt_d = '0;
        end else begin
          busy_d = 1'b0;
        end
      end

      S_SETTLE: begin
        if (set_cnt_q == SET_LAST) begin
          state_d   = S_CONV;
          set_cnt_d = '0;
          cnv_cnt_d = '0;
          cnv_d     = 1'b1;
        end else begin
          set_cnt_d = set_cnt_q + SET_W'(1);
        end
      end

      S_CONV: begin
        if (cnv_cnt_q == CNV_LAST) begin
          state_d   = S_SHIFT;
          cnv_cnt_d = '0;
          ph_d      = '0;
          bit_cnt_d = '0;
          to_cnt_d  = '0;
          got_d     = 1'b0;
        end else begin
          cnv_d     = 1'b1;
          cnv_cnt_d = cnv_cnt_q + CNV_W'(1);
        end
      end

      S_SHIFT: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = S_WAIT;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
        // Outputs describe the phase the counter moves into.
        if (state_d == S_SHIFT) begin
          sck_d = (ph_d >= PH_RISE);
          bv_d  = (ph_d == PH_RISE);
          if (ph_d == PH_RISE) begin
            bit_d = adc_sdo_i;
          end
        end
      end

      S_WAIT: begin
        if (got_d) begin
          state_d = S_OUT;
          ov_d    = 1'b1;
          od_d    = {ch_q, word_d};
        end
      end

      S_OUT: begin
        if (out_ready_i) begin
          ov_d = 1'b0;
          if (ch_q == CH_LAST) begin
            done_d = 1'b1;
`ifdef ADC_CTRL_CONTINUOUS_EN
            ch_d      = '0;
            state_d   = S_SETTLE;
            set_cnt_d = '0;
`else
            state_d = S_IDLE;
`endif
          end else begin
            ch_d      = ch_q + CH_W'(1);
            state_d   = S_SETTLE;
            set_cnt_d = '0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign ch_sel_o    = ch_q;
  assign adc_cnv_o   = cnv_q;
  assign adc_sck_o   = sck_q;
  assign bit_valid_o = bv_q;
  assign bit_o       = bit_q;
  assign out_valid_o = ov_q;
  assign out_data_o  = od_q;

endmodule

// File: tb/tb_adc_readout_ctrl.sv
// Scoreboard bench for adc_readout_ctrl with behavioural ADC and parser models.
module tb_adc_readout_ctrl;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 15;
  localparam int CH_W   = 2;
  localparam int OW     = CH_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic              adc_sdo_i = 1'b0;
  logic              word_valid_i = 1'b0;
  logic [DATA_W-1:0] word_i = '0;
  logic              out_ready_i = 1'b1;
  logic              busy_o, done_o, err_o, adc_cnv_o, adc_sck_o, bit_valid_o, bit_o, out_valid_o;
  logic [CH_W-1:0]   ch_sel_o;
  logic [OW-1:0]     out_data_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] pattern [NUM_CH] = '{default: '0};
  logic [OW-1:0]     exp_q [$];
  int suppress_ch = -1;
  int cyc = 0;
  int last_pulse = 0;
  int done_cnt = 0;
  bit t4_armed = 1'b0;

  always #5 clk = ~clk;

  adc_readout_ctrl #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SETTLE_CYC(8),
    .CONV_CYC(40), .SCK_HALF(2), .WORD_TO(4)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .ch_sel_o(ch_sel_o), .adc_cnv_o(adc_cnv_o), .adc_sck_o(adc_sck_o),
    .adc_sdo_i(adc_sdo_i), .bit_valid_o(bit_valid_o), .bit_o(bit_o),
    .word_valid_i(word_valid_i), .word_i(word_i), .out_valid_o(out_valid_o),
    .out_data_o(out_data_o), .out_ready_i(out_ready_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic queue_scan(input logic [DATA_W-1:0] p0, p1, p2, p3);
    pattern[0] = p0;
    pattern[1] = p1;
    pattern[2] = p2;
    pattern[3] = p3;
    for (int c = 0; c < NUM_CH; c++)
      exp_q.push_back({CH_W'(c), (c == suppress_ch) ? {DATA_W{1'b0}} : pattern[c]});
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, done_o, 1);
  endtask

  // ADC: MSB first, next bit presented after each SCK rise, restarts on CNV.
  initial begin : adc_model
    int idx = 0;
    logic sck_prev = 1'b0;
    logic [DATA_W-1:0] cur;
    forever begin
      @(negedge clk);
      if (adc_cnv_o) idx = 0;
      else if (adc_sck_o && !sck_prev) idx++;
      sck_prev = adc_sck_o;
      cur = pattern[ch_sel_o];
      adc_sdo_i = (idx < DATA_W) ? cur[DATA_W-1-idx] : 1'b0;
    end
  end

  // Parser: shifts in DATA_W bits, presents the word one cycle after the last bit.
  initial begin : parser_model
    int cnt = 0;
    bit pend = 1'b0;
    logic [DATA_W-1:0] sr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0;
        pend = 1'b0;
        word_valid_i = 1'b0;
      end else begin
        word_valid_i = pend;
        if (pend) word_i = sr;
        pend = 1'b0;
        if (bit_valid_o) begin
          sr = {sr[DATA_W-2:0], bit_o};
          cnt++;
          if (cnt == DATA_W) begin
            cnt = 0;
            pend = (int'(ch_sel_o) != suppress_ch);
          end
        end
      end
    end
  end

  initial begin : monitor
    logic err_prev = 1'b0;
    logic [OW-1:0] exp;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (bit_valid_o) last_pulse = cyc;
      if (done_o) done_cnt++;
      if (t4_armed && err_o && !err_prev) check("t4_err_latency", cyc - last_pulse, 5);
      err_prev = err_o;
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) check("sb_unexpected_out", out_valid_o, 0);
        else begin
          exp = exp_q.pop_front();
          check("sb_out", out_data_o, exp);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, bad, cnv_seen, pulses, sck_bad, pv_bad;
    logic exp_sck, exp_pv;
    logic [OW-1:0] held;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy_o, done_o, err_o, ch_sel_o, adc_cnv_o, adc_sck_o,
                            bit_valid_o, bit_o, out_valid_o, out_data_o}, 0);
    rst = 1'b0;
    @(negedge clk);

`ifdef ADC_CTRL_CONTINUOUS_EN
    queue_scan(15'h0101, 15'h0202, 15'h0303, 15'h0404);
    exp_q.push_back({2'd0, pattern[0]});
    exp_q.push_back({2'd1, pattern[1]});
    pulse_start();
    repeat (50) @(negedge clk);
    pulse_start();
    n = 0;
    while (exp_q.size() > 0 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    out_ready_i = 1'b0;
    check("t6_all_out", exp_q.size(), 0);
    check("t6_done_per_wrap", done_cnt, 1);
    check("t6_busy", busy_o, 1);
`else
    // T1 + T2: nominal scan, pulse timing measured on channel 0
    queue_scan(15'h1234, 15'h1235, 15'h1236, 15'h1237);
    pulse_start();
    check("t1_busy", busy_o, 1);
    n = 0;
    while (!adc_cnv_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t2_cnv_rise", adc_cnv_o, 1);
    n = 0;
    while (adc_cnv_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t2_cnv_len", n, 40);
    sck_bad = 0;
    pv_bad = 0;
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      exp_sck = (i < 60) && ((i % 4) >= 2);
      exp_pv  = (i < 60) && ((i % 4) == 2);
      if (adc_sck_o !== exp_sck) sck_bad++;
      if (bit_valid_o !== exp_pv) pv_bad++;
      if (bit_valid_o) pulses++;
      @(negedge clk);
    end
    check("t2_sck_duty", sck_bad, 0);
    check("t2_pulse_timing", pv_bad, 0);
    check("t2_pulse_count", pulses, 15);
    wait_done("t1_done", 600);
    check("t1_busy_at_done", busy_o, 1);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("t1_start_at_done_ignored", busy_o, 0);
    repeat (3) @(negedge clk);
    check("t1_done_once", done_cnt, 1);

    // T3: backpressure on channel 1
    queue_scan(15'h0001, 15'h4000, 15'h1111, 15'h7ffe);
    pulse_start();
    n = 0;
    while (!(out_valid_o && out_data_o[OW-1 -: CH_W] == 2'd1) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("t3_reach_ch1", {out_valid_o, out_data_o[OW-1 -: CH_W]}, 3'b101);
    out_ready_i = 1'b0;
    held = out_data_o;
    bad = 0;
    cnv_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (!out_valid_o || out_data_o !== held) bad++;
      if (adc_cnv_o) cnv_seen++;
    end
    check("t3_hold_stable", bad, 0);
    check("t3_no_cnv", cnv_seen, 0);
    out_ready_i = 1'b1;
    wait_done("t3_done", 600);
    repeat (2) @(negedge clk);

    // T4: parser word missing on channel 2
    suppress_ch = 2;
    queue_scan(15'h2222, 15'h3333, 15'h4444, 15'h5555);
    t4_armed = 1'b1;
    pulse_start();
    wait_done("t4_done", 800);
    check("t4_err_sticky", err_o, 1);
    t4_armed = 1'b0;
    suppress_ch = -1;
    repeat (2) @(negedge clk);
    queue_scan(15'h6789, 15'h0abc, 15'h7654, 15'h0fed);
    pulse_start();
    check("t4_err_cleared", err_o, 0);
    wait_done("t4_rescan_done", 600);
    check("t4_no_err", err_o, 0);
    repeat (2) @(negedge clk);

    // T5: reset during bit 7 of channel 0
    queue_scan(15'h1357, 15'h2468, 15'h3579, 15'h468a);
    pulse_start();
    n = 0;
    pulses = 0;
    while (pulses < 7 && n < 400) begin
      @(negedge clk);
      n++;
      if (bit_valid_o) pulses++;
    end
    check("t5_reach_bit7", pulses, 7);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("t5_reset_outputs", {busy_o, done_o, err_o, ch_sel_o, adc_cnv_o, adc_sck_o,
                               bit_valid_o, bit_o, out_valid_o, out_data_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    queue_scan(15'h7fff, 15'h0000, 15'h2aaa, 15'h5555);
    pulse_start();
    wait_done("t5_done", 600);
`endif

    repeat (5) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
